// File: rtl/la_cmd_bridge.sv
// Logic-analyzer host bridge for the BEC core: loads operands A/B from toggle-strobed
// LA writes, fires the core, then serves the captured result back one 32-bit word per read.
module la_cmd_bridge #(
  parameter int OP_W   = 163,
  parameter int WORD_W = 32
) (
  input  logic            wb_clk_i,
  input  logic            wb_rst_i,
  input  logic [63:0]     la_data_in,
  input  logic [63:0]     la_oenb,
  output logic [63:0]     la_data_out,
  output logic [OP_W-1:0] op_a_o,
  output logic [OP_W-1:0] op_b_o,
  output logic            start_o,
  input  logic            core_done_i,
  input  logic [OP_W-1:0] core_result_i
);

  localparam int NWORDS = (OP_W + WORD_W - 1) / WORD_W;
  localparam int EXT_W  = NWORDS * WORD_W;

  typedef enum logic [1:0] {IDLE = 2'd0, RUN = 2'd1, READOUT = 2'd2} state_t;

  state_t            r_state;
  logic [2:0]        r_togS1, r_togS2, r_togHist, r_ev;
  logic [WORD_W-1:0] r_wd1, r_wd2;
  logic [1:0]        r_sel1, r_sel2;
  logic [OP_W-1:0]   r_a, r_b, r_res;
  logic [3:0]        r_cntA, r_cntB;
  logic [2:0]        r_rdIdx;
  logic              r_resValid, r_err, r_start;

  logic [2:0]        w_togIn;
  logic              w_evWr, w_evStart, w_evRd, w_collide;
  logic              w_aLoaded, w_bLoaded;
  logic [EXT_W-1:0]  w_resExt;
  logic [WORD_W-1:0] w_rdata;
  logic              w_unused;

  // A masked toggle is replaced by stage 1 itself, so the pipeline freezes and no edge escapes.
  assign w_togIn = (la_data_in[36:34] & ~la_oenb[36:34]) | (r_togS1 & la_oenb[36:34]);

  always_ff @(posedge wb_clk_i or posedge wb_rst_i) begin
    if (wb_rst_i) begin
      r_togS1   <= '0;
      r_togS2   <= '0;
      r_togHist <= '0;
      r_ev      <= '0;
      r_wd1     <= '0;
      r_wd2     <= '0;
      r_sel1    <= '0;
      r_sel2    <= '0;
    end else begin
      r_togS1   <= w_togIn;
      r_togS2   <= r_togS1;
      r_togHist <= r_togS2;
      r_ev      <= r_togS2 ^ r_togHist;
      r_wd1     <= la_data_in[WORD_W-1:0];
      r_wd2     <= r_wd1;
      r_sel1    <= la_data_in[33:32];
      r_sel2    <= r_sel1;
    end
  end

  assign w_evWr    = r_ev[0];
  assign w_evStart = r_ev[1] & ~r_ev[0];
  assign w_evRd    = r_ev[2] & ~r_ev[1] & ~r_ev[0];
  assign w_collide = (r_ev[0] & (r_ev[1] | r_ev[2])) | (r_ev[1] & r_ev[2]);
  assign w_aLoaded = (r_cntA == 4'(NWORDS));
  assign w_bLoaded = (r_cntB == 4'(NWORDS));

  always_ff @(posedge wb_clk_i or posedge wb_rst_i) begin
    if (wb_rst_i) begin
      r_state    <= IDLE;
      r_a        <= '0;
      r_b        <= '0;
      r_res      <= '0;
      r_cntA     <= '0;
      r_cntB     <= '0;
      r_rdIdx    <= '0;
      r_resValid <= 1'b0;
      r_err      <= 1'b0;
      r_start    <= 1'b0;
    end else begin
      r_start <= 1'b0;
      if (w_evWr) begin
        case (r_sel2)
          2'd0: begin
            if (r_state == IDLE) begin
              r_a <= {r_a[OP_W-WORD_W-1:0], r_wd2};
              if (!w_aLoaded) r_cntA <= r_cntA + 4'd1;
            end else r_err <= 1'b1;
          end
          2'd1: begin
            if (r_state == IDLE) begin
              r_b <= {r_b[OP_W-WORD_W-1:0], r_wd2};
              if (!w_bLoaded) r_cntB <= r_cntB + 4'd1;
            end else r_err <= 1'b1;
          end
          2'd2: begin
            if (r_state != RUN) begin
              r_a        <= '0;
              r_b        <= '0;
              r_cntA     <= '0;
              r_cntB     <= '0;
              r_rdIdx    <= '0;
              r_resValid <= 1'b0;
              r_err      <= 1'b0;
              r_state    <= IDLE;
            end else r_err <= 1'b1;
          end
          default: r_err <= 1'b1;
        endcase
      end else if (w_evStart) begin
        if (r_state == IDLE && w_aLoaded && w_bLoaded) begin
          r_start <= 1'b1;
          r_state <= RUN;
        end else r_err <= 1'b1;
      end else if (w_evRd && r_state == READOUT) begin
        if (r_rdIdx == 3'(NWORDS - 1)) begin
          r_state    <= IDLE;
          r_resValid <= 1'b0;
          r_cntA     <= '0;
          r_cntB     <= '0;
          r_rdIdx    <= '0;
        end else r_rdIdx <= r_rdIdx + 3'd1;
      end
      // Done arriving alongside the start pulse belongs to a previous run and is dropped.
      if (r_state == RUN && core_done_i && !r_start) begin
        r_res      <= core_result_i;
        r_resValid <= 1'b1;
        r_rdIdx    <= '0;
        r_state    <= READOUT;
      end
      if (w_collide) r_err <= 1'b1;
    end
  end

  assign w_resExt = EXT_W'(r_res);

  always_comb begin
    w_rdata = '0;
    if (r_state == READOUT) begin
      for (int k = 0; k < NWORDS; k++) begin
        if (r_rdIdx == 3'(k)) w_rdata = w_resExt[(NWORDS-1-k)*WORD_W +: WORD_W];
      end
    end
  end

  assign la_data_out = {23'd0, r_err, w_bLoaded, w_aLoaded, r_resValid, r_rdIdx, r_state, w_rdata};
  assign op_a_o      = r_a;
  assign op_b_o      = r_b;
  assign start_o     = r_start;
  assign w_unused    = ^{la_data_in[63:37], la_oenb[63:37], la_oenb[33:0]};

endmodule

// File: tb/tb_la_cmd_bridge.sv
// Directed bench for la_cmd_bridge: table of host operations with expected status/rdata,
// plus hand sequences for start latency, masking, collisions, abort and async reset.
module tb_la_cmd_bridge;

  localparam int OP_W = 163;
  localparam logic [1:0] KWR = 2'd0;
  localparam logic [1:0] KST = 2'd1;
  localparam logic [1:0] KRD = 2'd2;
  localparam logic [OP_W-1:0] RESULT = 163'h5_DEADBEEF_01234567_89ABCDEF_CAFEF00D_12345678;
  localparam logic [OP_W-1:0] EXP_A  = 163'h1_00000002_00000003_00000004_00000005_00000006;
  localparam logic [OP_W-1:0] EXP_B  = 163'h1_00000012_00000013_00000014_00000015_00000016;

  typedef struct {
    logic [1:0]  kind;
    logic [1:0]  sel;
    logic [31:0] data;
    logic [1:0]  expState;
    logic        expErr;
    logic        expA;
    logic        expB;
    logic        expValid;
    logic [2:0]  expIdx;
    logic [31:0] expRdata;
  } vec_t;

  logic            wb_clk_i = 1'b0;
  logic            wb_rst_i;
  logic [63:0]     la_data_in;
  logic [63:0]     la_oenb;
  logic [63:0]     la_data_out;
  logic [OP_W-1:0] op_a_o, op_b_o;
  logic            start_o;
  logic            core_done_i;
  logic [OP_W-1:0] core_result_i;

  vec_t vecs[$];
  int   checkCount = 0;
  int   passCount  = 0;
  int   startPulses = 0;
  logic [31:0] words [6] = '{32'h00000005, 32'hDEADBEEF, 32'h01234567,
                             32'h89ABCDEF, 32'hCAFEF00D, 32'h12345678};

  la_cmd_bridge #(.OP_W(OP_W), .WORD_W(32)) dut (
    .wb_clk_i      (wb_clk_i),
    .wb_rst_i      (wb_rst_i),
    .la_data_in    (la_data_in),
    .la_oenb       (la_oenb),
    .la_data_out   (la_data_out),
    .op_a_o        (op_a_o),
    .op_b_o        (op_b_o),
    .start_o       (start_o),
    .core_done_i   (core_done_i),
    .core_result_i (core_result_i)
  );

  always #5 wb_clk_i = ~wb_clk_i;

  always @(posedge wb_clk_i) if (start_o) startPulses++;

  function automatic void addVec(logic [1:0] k, logic [1:0] s, logic [31:0] d, logic [1:0] st,
                                 logic e, logic a, logic b, logic v, logic [2:0] idx, logic [31:0] rd);
    vec_t t;
    t.kind = k; t.sel = s; t.data = d; t.expState = st; t.expErr = e;
    t.expA = a; t.expB = b; t.expValid = v; t.expIdx = idx; t.expRdata = rd;
    vecs.push_back(t);
  endfunction

  task automatic checkOutput(input string name, input logic [191:0] act, input logic [191:0] exp);
    checkCount++;
    if (act === exp) passCount++;
    else $display("[TB] FAIL %s: got %0h, expected %0h", name, act, exp);
  endtask

  task automatic applyStimulus(input logic [1:0] kind, input logic [1:0] sel, input logic [31:0] data);
    @(negedge wb_clk_i);
    la_data_in[31:0]  = data;
    la_data_in[33:32] = sel;
    @(negedge wb_clk_i);
    case (kind)
      KWR:     la_data_in[34] = ~la_data_in[34];
      KST:     la_data_in[35] = ~la_data_in[35];
      default: la_data_in[36] = ~la_data_in[36];
    endcase
    repeat (6) @(negedge wb_clk_i);
  endtask

  task automatic checkStatus(input string name, input logic e, input logic b, input logic a,
                             input logic v, input logic [1:0] st);
    checkOutput(name, 192'({la_data_out[40:37], la_data_out[33:32]}), 192'({e, b, a, v, st}));
  endtask

  task automatic runVectors(input int lo, input int hi);
    for (int i = lo; i < hi; i++) begin
      applyStimulus(vecs[i].kind, vecs[i].sel, vecs[i].data);
      checkStatus($sformatf("vec%0d status", i), vecs[i].expErr, vecs[i].expB, vecs[i].expA,
                  vecs[i].expValid, vecs[i].expState);
      checkOutput($sformatf("vec%0d rdata", i), 192'(la_data_out[31:0]), 192'(vecs[i].expRdata));
      if (vecs[i].expState == 2'd2)
        checkOutput($sformatf("vec%0d rd_idx", i), 192'(la_data_out[36:34]), 192'(vecs[i].expIdx));
    end
  endtask

  task automatic doDone();
    @(negedge wb_clk_i);
    core_done_i   = 1'b1;
    core_result_i = RESULT;
    @(negedge wb_clk_i);
    core_done_i   = 1'b0;
    @(negedge wb_clk_i);
  endtask

  initial begin
    int s0, s1, s2, s3, s4, s5;
    logic [4:0] seq;

    wb_rst_i      = 1'b1;
    la_data_in    = '0;
    la_oenb       = '0;
    core_done_i   = 1'b0;
    core_result_i = '0;

    s0 = vecs.size();
    for (int i = 1; i <= 5; i++) addVec(KWR, 2'd0, 32'(i), 2'd0, 1'b0, 1'b0, 1'b0, 1'b0, 3'd0, 32'd0);
    addVec(KST, 2'd0, 32'd0, 2'd0, 1'b1, 1'b0, 1'b0, 1'b0, 3'd0, 32'd0);
    addVec(KWR, 2'd2, 32'd0, 2'd0, 1'b0, 1'b0, 1'b0, 1'b0, 3'd0, 32'd0);
    s1 = vecs.size();
    addVec(KWR, 2'd2, 32'd0, 2'd0, 1'b0, 1'b0, 1'b0, 1'b0, 3'd0, 32'd0);
    for (int i = 1; i <= 6; i++) addVec(KWR, 2'd0, 32'(i), 2'd0, 1'b0, (i == 6), 1'b0, 1'b0, 3'd0, 32'd0);
    for (int i = 1; i <= 6; i++) addVec(KWR, 2'd1, 32'(16 + i), 2'd0, 1'b0, 1'b1, (i == 6), 1'b0, 3'd0, 32'd0);
    s2 = vecs.size();
    addVec(KWR, 2'd0, 32'hAA, 2'd1, 1'b1, 1'b1, 1'b1, 1'b0, 3'd0, 32'd0);
    s3 = vecs.size();
    for (int i = 1; i <= 5; i++) addVec(KRD, 2'd0, 32'd0, 2'd2, 1'b1, 1'b1, 1'b1, 1'b1, 3'(i), words[i]);
    addVec(KRD, 2'd0, 32'd0, 2'd0, 1'b1, 1'b0, 1'b0, 1'b0, 3'd0, 32'd0);
    s4 = vecs.size();
    for (int i = 1; i <= 3; i++) addVec(KRD, 2'd0, 32'd0, 2'd2, 1'b0, 1'b1, 1'b1, 1'b1, 3'(i), words[i]);
    addVec(KWR, 2'd2, 32'd0, 2'd0, 1'b0, 1'b0, 1'b0, 1'b0, 3'd0, 32'd0);
    s5 = vecs.size();

    repeat (2) @(negedge wb_clk_i);
    checkOutput("reset la_data_out", 192'(la_data_out), 192'(0));
    checkOutput("reset start_o", 192'(start_o), 192'(0));
    checkOutput("reset op_a", 192'(op_a_o), 192'(0));
    wb_rst_i = 1'b0;

    runVectors(s0, s1);
    checkOutput("no start after 5 A words", 192'(startPulses), 192'(0));

    runVectors(s1, s2);
    checkOutput("op_a loaded", 192'(op_a_o), 192'(EXP_A));
    checkOutput("op_b loaded", 192'(op_b_o), 192'(EXP_B));

    seq = '0;
    @(negedge wb_clk_i);
    la_data_in[35] = ~la_data_in[35];
    for (int k = 0; k < 5; k++) begin
      @(posedge wb_clk_i);
      #1 seq = {seq[3:0], start_o};
    end
    checkOutput("start latency", 192'(seq), 192'(5'b00010));
    repeat (3) @(negedge wb_clk_i);
    checkStatus("run status", 1'b0, 1'b1, 1'b1, 1'b0, 2'd1);
    checkOutput("single start pulse", 192'(startPulses), 192'(1));

    runVectors(s2, s3);
    checkOutput("op_a kept on RUN write", 192'(op_a_o), 192'(EXP_A));

    doDone();
    checkStatus("readout status", 1'b1, 1'b1, 1'b1, 1'b1, 2'd2);
    checkOutput("readout word0", 192'(la_data_out[31:0]), 192'(words[0]));
    checkOutput("readout idx0", 192'(la_data_out[36:34]), 192'(0));

    runVectors(s3, s4);
    checkOutput("op_a kept after readout", 192'(op_a_o), 192'(EXP_A));
    checkOutput("op_b kept after readout", 192'(op_b_o), 192'(EXP_B));

    la_oenb[34] = 1'b1;
    applyStimulus(KWR, 2'd0, 32'h77);
    applyStimulus(KWR, 2'd0, 32'h77);
    la_oenb[34] = 1'b0;
    repeat (4) @(negedge wb_clk_i);
    checkOutput("masked write ignored", 192'(op_a_o), 192'(EXP_A));
    checkStatus("masked status", 1'b1, 1'b0, 1'b0, 1'b0, 2'd0);

    applyStimulus(KWR, 2'd2, 32'd0);
    checkOutput("clear resets err", 192'(la_data_out[40]), 192'(0));

    @(negedge wb_clk_i);
    la_data_in[31:0]  = 32'h99;
    la_data_in[33:32] = 2'd0;
    @(negedge wb_clk_i);
    la_data_in[34] = ~la_data_in[34];
    la_data_in[35] = ~la_data_in[35];
    repeat (6) @(negedge wb_clk_i);
    checkOutput("collision write done", 192'(op_a_o), 192'(32'h99));
    checkStatus("collision status", 1'b1, 1'b0, 1'b0, 1'b0, 2'd0);
    checkOutput("collision start dropped", 192'(startPulses), 192'(1));

    runVectors(s1, s2);
    applyStimulus(KST, 2'd0, 32'd0);
    checkStatus("second run status", 1'b0, 1'b1, 1'b1, 1'b0, 2'd1);
    checkOutput("second start pulse", 192'(startPulses), 192'(2));
    doDone();
    runVectors(s4, s5);
    checkOutput("abort clears op_a", 192'(op_a_o), 192'(0));

    runVectors(s1, s2);
    applyStimulus(KST, 2'd0, 32'd0);
    checkStatus("third run status", 1'b0, 1'b1, 1'b1, 1'b0, 2'd1);
    @(posedge wb_clk_i);
    #3 wb_rst_i = 1'b1;
    #1;
    checkOutput("async reset la_data_out", 192'(la_data_out), 192'(0));
    checkOutput("async reset start_o", 192'(start_o), 192'(0));
    checkOutput("async reset op_a", 192'(op_a_o), 192'(0));
    la_data_in = '0;
    @(negedge wb_clk_i);
    wb_rst_i = 1'b0;
    repeat (8) @(negedge wb_clk_i);
    checkOutput("no restart after reset", 192'(startPulses), 192'(3));
    checkOutput("idle after reset", 192'(la_data_out), 192'(0));

    $display("%0d/%0d checks passed", passCount, checkCount);
    $finish;
  end

endmodule
